// File: rtl/mmio_timer_led_if.sv
// CPU data-bus signals seen by the timer/LED responder.
// The master drives the request and the slave returns registered read data and a bus-error pulse.
interface mmio_timer_led_if;
    logic        rw;
    logic [63:0] addr;
    logic [63:0] write;
    logic [63:0] read;
    logic        exception;

    modport master (
        output rw,
        output addr,
        output write,
        input  read,
        input  exception
    );

    modport slave (
        input  rw,
        input  addr,
        input  write,
        output read,
        output exception
    );
endinterface

// File: rtl/mmio_timer_led.sv
// MMIO responder: 8-bit LED register, prescaled 64-bit tick counter with compare/auto-reload, sticky match.
// Optional macro TIMER_IRQ_EN adds CTRL.IRQEN storage and drives irq; without it, irq is tied low.
module mmio_timer_led #(
    parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0001_0000,
    parameter int unsigned PRESCALE  = 25000
) (
    input  logic               clk,
    input  logic               rst_n,
    mmio_timer_led_if.slave    bus,
    output logic [7:0]         led,
    output logic               irq
);

    localparam logic [5:0] OFF_LED     = 6'h00;
    localparam logic [5:0] OFF_CTRL    = 6'h08;
    localparam logic [5:0] OFF_COUNT   = 6'h10;
    localparam logic [5:0] OFF_COMPARE = 6'h18;
    localparam logic [5:0] OFF_STATUS  = 6'h20;

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

    logic          hit;
    logic [5:0]    off;
    logic          legal;
    logic          acc_ok;
    logic          acc_err;
    logic          rd_ok;
    logic          wr_led;
    logic          wr_ctrl;
    logic          wr_count;
    logic          wr_compare;
    logic          wr_status;
    logic [63:0]   rd_data;

    logic          ctrl_en;
    logic          ctrl_ar;
    logic          ctrl_ie;
    logic [63:0]   count;
    logic [63:0]   compare;
    logic          match;
    logic [PW-1:0] pre;
    logic          tick;
    logic          cmp_eq;

    // Address decode: only 8-byte aligned offsets up to STATUS are legal inside the window.
    always_comb begin
        hit        = (bus.addr[63:6] == BASE_ADDR[63:6]);
        off        = bus.addr[5:0];
        legal      = (off[2:0] == 3'b000) && (off <= OFF_STATUS);
        acc_ok     = hit && legal;
        acc_err    = hit && !legal;
        rd_ok      = acc_ok && !bus.rw;
        wr_led     = acc_ok && bus.rw && (off == OFF_LED);
        wr_ctrl    = acc_ok && bus.rw && (off == OFF_CTRL);
        wr_count   = acc_ok && bus.rw && (off == OFF_COUNT);
        wr_compare = acc_ok && bus.rw && (off == OFF_COMPARE);
        wr_status  = acc_ok && bus.rw && (off == OFF_STATUS);
    end

    always_comb begin
        rd_data = 64'd0;
        if (rd_ok) begin
            case (off)
                OFF_LED:     rd_data = {56'd0, led};
                OFF_CTRL:    rd_data = {61'd0, ctrl_ie, ctrl_ar, ctrl_en};
                OFF_COUNT:   rd_data = count;
                OFF_COMPARE: rd_data = compare;
                OFF_STATUS:  rd_data = {63'd0, match};
                default:     rd_data = 64'd0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.read      <= 64'd0;
            bus.exception <= 1'b0;
        end else begin
            bus.read      <= rd_data;
            bus.exception <= acc_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led     <= 8'd0;
            ctrl_en <= 1'b0;
            ctrl_ar <= 1'b0;
            compare <= '1;
        end else begin
            if (wr_led)     led     <= bus.write[7:0];
            if (wr_compare) compare <= bus.write;
            if (wr_ctrl) begin
                ctrl_en <= bus.write[0];
                ctrl_ar <= bus.write[1];
            end
        end
    end

`ifdef TIMER_IRQ_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_ie <= 1'b0;
        end else if (wr_ctrl) begin
            ctrl_ie <= bus.write[2];
        end
    end
`else
    assign ctrl_ie = 1'b0;
`endif

    assign tick   = ctrl_en && (pre == PS_LAST);
    assign cmp_eq = (count == compare);

    // A CTRL write that drops EN restarts the prescaler so re-enabling gives a full first period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre <= '0;
        end else if (wr_ctrl && !bus.write[0]) begin
            pre <= '0;
        end else if (!ctrl_en || tick) begin
            pre <= '0;
        end else begin
            pre <= pre + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 64'd0;
        end else if (wr_count) begin
            count <= bus.write;
        end else if (tick) begin
            if (cmp_eq && ctrl_ar) count <= 64'd0;
            else                   count <= count + 64'd1;
        end
    end

    // A match on this tick wins over a same-cycle write-1-to-clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match <= 1'b0;
        end else if (tick && cmp_eq) begin
            match <= 1'b1;
        end else if (wr_status && bus.write[0]) begin
            match <= 1'b0;
        end
    end

`ifdef TIMER_IRQ_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq <= 1'b0;
        end else begin
            irq <= match && ctrl_ie;
        end
    end
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_mmio_timer_led.sv
// Directed bench for mmio_timer_led with PRESCALE=4; expected values are hand-computed.
module tb_mmio_timer_led;
    localparam logic [63:0] BASE = 64'h0000_0000_0001_0000;

    logic       clk;
    logic       rst_n;
    logic [7:0] led;
    logic       irq;
    int         tests;
    int         fails;

    mmio_timer_led_if bus ();

    mmio_timer_led #(.BASE_ADDR(BASE), .PRESCALE(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .led   (led),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive request, take the edge, settle; read/exception then reflect this request.
    task automatic access(input logic w, input logic [63:0] a, input logic [63:0] d);
        bus.rw    = w;
        bus.addr  = a;
        bus.write = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] exp_cnt [16];
        logic [63:0] exp_ctrl;
        logic        exp_irq5;
        exp_cnt = '{64'd0, 64'd0, 64'd0, 64'd0, 64'd1, 64'd1, 64'd1, 64'd1,
                    64'd2, 64'd2, 64'd2, 64'd2, 64'd0, 64'd0, 64'd0, 64'd0};
`ifdef TIMER_IRQ_EN
        exp_ctrl = 64'd5;
        exp_irq5 = 1'b1;
`else
        exp_ctrl = 64'd1;
        exp_irq5 = 1'b0;
`endif
        tests = 0;
        fails = 0;
        rst_n     = 1'b0;
        bus.rw    = 1'b0;
        bus.addr  = 64'd0;
        bus.write = 64'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_led", {56'd0, led}, 64'd0);
        chk("rst_read", bus.read, 64'd0);
        chk("rst_exc", {63'd0, bus.exception}, 64'd0);
        chk("rst_irq", {63'd0, irq}, 64'd0);
        rst_n = 1'b1;

        access(1'b0, BASE + 64'h18, 64'd0);
        chk("rst_compare", bus.read, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("rst_compare_exc", {63'd0, bus.exception}, 64'd0);

        access(1'b1, BASE + 64'h00, 64'hDEAD_BEEF_0000_00B6);
        chk("led_write", {56'd0, led}, 64'hB6);
        access(1'b0, BASE + 64'h00, 64'd0);
        chk("led_readback", bus.read, 64'h0000_0000_0000_00B6);

        access(1'b0, BASE + 64'h03, 64'd0);
        chk("misalign_exc", {63'd0, bus.exception}, 64'd1);
        chk("misalign_read", bus.read, 64'd0);
        access(1'b0, 64'd0, 64'd0);
        chk("misalign_exc_end", {63'd0, bus.exception}, 64'd0);

        access(1'b1, BASE + 64'h28, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("oob_write_exc", {63'd0, bus.exception}, 64'd1);
        access(1'b1, BASE + 64'h01, 64'h0000_0000_0000_0011);
        chk("misalign_write_exc", {63'd0, bus.exception}, 64'd1);
        chk("misalign_write_led", {56'd0, led}, 64'hB6);
        access(1'b0, BASE + 64'h00, 64'd0);
        chk("led_after_err", bus.read, 64'hB6);
        access(1'b0, BASE + 64'h40, 64'd0);
        chk("miss_read", bus.read, 64'd0);
        chk("miss_exc", {63'd0, bus.exception}, 64'd0);
        access(1'b1, BASE + 64'h40, 64'h55);
        chk("miss_write_led", {56'd0, led}, 64'hB6);

        access(1'b1, BASE + 64'h18, 64'd2);
        access(1'b1, BASE + 64'h10, 64'd0);
        access(1'b1, BASE + 64'h08, 64'd3);
        for (int k = 1; k <= 16; k++) begin
            access(1'b0, BASE + 64'h10, 64'd0);
            chk($sformatf("count_k%0d", k), bus.read, exp_cnt[k-1]);
        end
        access(1'b0, BASE + 64'h20, 64'd0);
        chk("match_set", bus.read, 64'd1);
        access(1'b1, BASE + 64'h20, 64'd1);
        access(1'b0, BASE + 64'h20, 64'd0);
        chk("match_w1c", bus.read, 64'd0);

        // k=20 is a tick edge: the CPU write must win over the increment.
        access(1'b1, BASE + 64'h10, 64'd100);
        access(1'b0, BASE + 64'h10, 64'd0);
        chk("count_write_on_tick", bus.read, 64'd100);
        access(1'b1, BASE + 64'h18, 64'd100);
        access(1'b0, BASE + 64'h10, 64'd0);
        chk("count_hold", bus.read, 64'd100);
        // k=24 is a tick edge with COUNT==COMPARE: match beats the W1C.
        access(1'b1, BASE + 64'h20, 64'd1);
        access(1'b0, BASE + 64'h20, 64'd0);
        chk("match_beats_w1c", bus.read, 64'd1);
        access(1'b0, BASE + 64'h10, 64'd0);
        chk("autoreload", bus.read, 64'd0);
        chk("irq_no_ie", {63'd0, irq}, 64'd0);

        access(1'b1, BASE + 64'h08, 64'd0);
        access(1'b1, BASE + 64'h20, 64'd1);
        access(1'b1, BASE + 64'h18, 64'd0);
        access(1'b1, BASE + 64'h10, 64'd0);
        repeat (6) access(1'b0, BASE + 64'h10, 64'd0);
        chk("count_frozen", bus.read, 64'd0);

        access(1'b1, BASE + 64'h08, 64'd5);
        for (int j = 1; j <= 5; j++) begin
            access(1'b0, BASE + 64'h08, 64'd0);
            chk($sformatf("ctrl_rb_j%0d", j), bus.read, exp_ctrl);
            chk($sformatf("irq_j%0d", j), {63'd0, irq}, (j == 5) ? {63'd0, exp_irq5} : 64'd0);
        end
        access(1'b0, BASE + 64'h20, 64'd0);
        chk("match_cmp0", bus.read, 64'd1);
        access(1'b0, BASE + 64'h10, 64'd0);
        chk("count_no_reload", bus.read, 64'd1);

        access(1'b0, BASE + 64'h00, 64'd0);
        chk("pre_reset_read", bus.read, 64'hB6);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_led", {56'd0, led}, 64'd0);
        chk("async_rst_read", bus.read, 64'd0);
        chk("async_rst_irq", {63'd0, irq}, 64'd0);
        #2;
        rst_n = 1'b1;
        access(1'b0, BASE + 64'h10, 64'd0);
        chk("post_rst_count", bus.read, 64'd0);
        access(1'b0, BASE + 64'h08, 64'd0);
        chk("post_rst_ctrl", bus.read, 64'd0);
        access(1'b0, BASE + 64'h18, 64'd0);
        chk("post_rst_compare", bus.read, 64'hFFFF_FFFF_FFFF_FFFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mmio_timer_led.md
Name: mmio_timer_led

Overview:
Memory-mapped responder on the CPU data bus (clk, rw, addr, read, write, exception), sitting beside the main memory responder. Decodes a fixed address window and holds three things: an 8-bit LED register, a prescaled 64-bit tick counter with compare/auto-reload, and a sticky match status with an optional interrupt. Reports bus errors for bad accesses inside its window through the exception line.

Parameters:
BASE_ADDR, 64'h0000_0000_0001_0000, window base; 64-byte window, aligned to 64 bytes.
PRESCALE, 25000, clk cycles per counter tick; 25 MHz gives a 1 ms tick. Valid range is 1 or more.

Ports:
clk  in  1  system clock.
rst_n  in  1  asynchronous active-low reset.
rw  in  1  1 = write, 0 = read; sampled every cycle.
addr  in  64  byte address from the CPU.
write  in  64  write data from the CPU.
read  out  64  read data, registered.
exception  out  1  bus error pulse, registered.
led  out  8  LED register contents.
irq  out  1  level interrupt.

Behaviour:
- Reset values (rst_n low, asynchronous): read=0, exception=0, led=0, irq=0, CTRL=0, COUNT=0, COMPARE=all-ones, STATUS=0, prescaler=0.
- Hit: addr[63:6]==BASE_ADDR[63:6].
- Legal offsets (addr[5:0]):
  - 0x00 LED, RW, bits[7:0]; upper bits read 0.
  - 0x08 CTRL, RW: bit0 EN, bit1 AUTORELOAD, bit2 IRQEN.
  - 0x10 COUNT, RW.
  - 0x18 COMPARE, RW.
  - 0x20 STATUS, bit0 MATCH, write-1-to-clear.
- Error: a hit with addr[2:0]!=0 or offset>0x20 -> exception=1 the next cycle for one cycle. Writes are discarded and read=0.
- Miss: no register change; read=0 and exception=0 the next cycle.
- Write: rw=1 and legal hit -> register updated at this posedge; visible on led and on readback from the next cycle.
- Read: rw=0 and legal hit -> register value appears on read one cycle later. The value is a snapshot at the sampling edge.
- A continuous read at the same address updates read every cycle.
- Prescaler while EN=1:
  - Counts 0..PRESCALE-1.
  - At PRESCALE-1 it wraps to 0 and asserts a one-cycle tick.
- EN=0: prescaler held at 0; COUNT frozen.
- On tick:
  - If COUNT==COMPARE: MATCH<=1, and COUNT<=0 if AUTORELOAD, else COUNT<=COUNT+1.
  - Otherwise COUNT<=COUNT+1, wrapping 2^64-1 -> 0.
- Simultaneous events:
  - CPU write to COUNT beats a tick increment in the same cycle.
  - MATCH set beats a W1C in the same cycle.
  - A write to CTRL that clears EN also zeroes the prescaler.
- irq = MATCH & IRQEN, registered: asserted one cycle after both are true.
- Reset mid-operation aborts everything and returns to the reset values immediately.

Optional Feature:
TIMER_IRQ_EN
- Defined: irq behaves as above; CTRL bit2 is writable and reads back.
- Undefined: irq tied 0; CTRL bit2 is not stored and reads 0. The irq port stays present.

Test Plan:
- Reset, then a read at BASE+0x18 -> read=64'hFFFF_FFFF_FFFF_FFFF one cycle later. led=0, exception=0.
- Write 8'hB6 to BASE+0x00 -> led=8'hB6 next cycle. Read back gives 64'h00000000000000B6.
- PRESCALE=4, COMPARE=2, CTRL=3 (EN+AUTORELOAD):
  - COUNT reads 0,1,2,0 at ticks every 4 clk.
  - MATCH=1 after the third tick.
  - Write 1 to STATUS -> MATCH=0.
- Error accesses:
  - Read BASE+0x03 -> exception pulse of exactly 1 cycle, read=0.
  - Write BASE+0x28 -> exception pulse, no register changed.
  - Read BASE+0x40 (miss) -> exception=0, read=0.
- Simultaneous events:
  - A write of COUNT=100 on a tick cycle -> COUNT reads 100, not the incremented value.
  - A W1C on the same cycle as a match -> MATCH stays 1.
- With TIMER_IRQ_EN, CTRL=5, COMPARE=0 -> irq=1 one cycle after MATCH sets. Assert rst_n=0 mid-count -> irq, COUNT and led go to 0 immediately.
